// File: rtl/crop_stream_tx.sv
// crop_stream_tx: forwards a fixed-size crop window of a row-major input frame
// onto the conv2d_input stream, under ap_start/ap_done block control.
// A 2-entry output FIFO decouples the CNN backpressure from the input side.
module crop_stream_tx #(
  parameter int FP_TOTAL = 16,
  parameter int IN_ROWS  = 100,
  parameter int IN_COLS  = 160,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int Y_W      = $clog2(IN_ROWS),
  parameter int X_W      = $clog2(IN_COLS)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                ap_start,
  output logic                ap_done,
  output logic                ap_idle,
  output logic                ap_ready,
  input  logic [Y_W-1:0]      crop_y,
  input  logic [X_W-1:0]      crop_x,
  input  logic [FP_TOTAL-1:0] frame_in_TDATA,
  input  logic                frame_in_TVALID,
  output logic                frame_in_TREADY,
  output logic [FP_TOTAL-1:0] conv2d_input_V_data_0_V_TDATA,
  output logic                conv2d_input_V_data_0_V_TVALID,
  input  logic                conv2d_input_V_data_0_V_TREADY
);

  localparam logic [Y_W-1:0] Y_MAX    = Y_W'(IN_ROWS - OUT_ROWS);
  localparam logic [X_W-1:0] X_MAX    = X_W'(IN_COLS - OUT_COLS);
  localparam logic [Y_W-1:0] LAST_ROW = Y_W'(IN_ROWS - 1);
  localparam logic [X_W-1:0] LAST_COL = X_W'(IN_COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [Y_W-1:0]        row;
  logic [X_W-1:0]        col;
  logic [Y_W-1:0]        org_y;
  logic [X_W-1:0]        org_x;
  logic                  done;
  logic                  ready;
  logic                  idle;
  logic                  in_ready;

  logic [1:0]            fifo_cnt;
  logic [1:0]            cnt_next;
  logic [FP_TOTAL-1:0]   head;
  logic [FP_TOTAL-1:0]   tail;
  logic                  out_valid;

  logic                  in_hs;
  logic                  out_hs;
  logic                  in_window;
  logic                  push;
  logic                  last_pixel;
  logic [Y_W:0]          y_end;
  logic [X_W:0]          x_end;

  assign in_hs  = frame_in_TVALID & in_ready;
  assign out_hs = out_valid & conv2d_input_V_data_0_V_TREADY;

  // Window bounds computed one bit wider so origin+size cannot wrap.
  assign y_end = {1'b0, org_y} + (Y_W + 1)'(OUT_ROWS);
  assign x_end = {1'b0, org_x} + (X_W + 1)'(OUT_COLS);
  assign in_window = (row >= org_y) && ({1'b0, row} < y_end) &&
                     (col >= org_x) && ({1'b0, col} < x_end);
  assign push       = in_hs & in_window;
  assign last_pixel = (row == LAST_ROW) && (col == LAST_COL);

  assign ap_done         = done;
  assign ap_ready        = ready;
  assign ap_idle         = idle;
  assign frame_in_TREADY = in_ready;
  assign conv2d_input_V_data_0_V_TDATA  = head;
  assign conv2d_input_V_data_0_V_TVALID = out_valid;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    cnt_next = fifo_cnt;
    if (push && !out_hs) begin
      cnt_next = fifo_cnt + 2'd1;
    end else if (!push && out_hs) begin
      cnt_next = fifo_cnt - 2'd1;
    end
  end

  // Two-entry FIFO: head drives the output, tail holds the second pixel.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      head      <= '0;
      tail      <= '0;
      fifo_cnt  <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      fifo_cnt  <= cnt_next;
      out_valid <= (cnt_next != 2'd0);
      if (out_hs && fifo_cnt == 2'd2) begin
        head <= tail;
      end
      if (push) begin
        if (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && out_hs)) begin
          head <= frame_in_TDATA;
        end else begin
          tail <= frame_in_TDATA;
        end
      end
    end
  end

  // Block control FSM with frame counters; all handshake outputs registered.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= S_IDLE;
      row      <= '0;
      col      <= '0;
      org_y    <= '0;
      org_x    <= '0;
      done     <= 1'b0;
      ready    <= 1'b0;
      idle     <= 1'b1;
      in_ready <= 1'b0;
    end else begin
      done  <= 1'b0;
      ready <= 1'b0;
      case (state)
        S_IDLE: begin
          idle     <= 1'b1;
          in_ready <= 1'b0;
          if (ap_start) begin
            org_y    <= (crop_y > Y_MAX) ? Y_MAX : crop_y;
            org_x    <= (crop_x > X_MAX) ? X_MAX : crop_x;
            row      <= '0;
            col      <= '0;
            ready    <= 1'b1;
            idle     <= 1'b0;
            in_ready <= 1'b1;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          // Registered view of "FIFO has room"; a same-cycle pop is not seen.
          in_ready <= (cnt_next < 2'd2);
          if (in_hs) begin
            if (col == LAST_COL) begin
              col <= '0;
              row <= last_pixel ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pixel) begin
              in_ready <= 1'b0;
              state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          in_ready <= 1'b0;
          if (fifo_cnt == 2'd0) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          idle  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_stream_tx.sv
// Self-checking bench for crop_stream_tx: ramp frames, scoreboard queue of
// expected window pixels filled at input handshake, drained at output beats.
module tb_crop_stream_tx;

  localparam int IR    = 100;
  localparam int IC    = 160;
  localparam int OR    = 48;
  localparam int OC    = 48;
  localparam int TOTAL = IR * IC;

  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [6:0]  crop_y = '0;
  logic [7:0]  crop_x = '0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  crop_stream_tx dut (
    .ap_clk                         (clk),
    .ap_rst                         (ap_rst),
    .ap_start                       (ap_start),
    .ap_done                        (ap_done),
    .ap_idle                        (ap_idle),
    .ap_ready                       (ap_ready),
    .crop_y                         (crop_y),
    .crop_x                         (crop_x),
    .frame_in_TDATA                 (in_data),
    .frame_in_TVALID                (in_valid),
    .frame_in_TREADY                (in_ready),
    .conv2d_input_V_data_0_V_TDATA  (out_data),
    .conv2d_input_V_data_0_V_TVALID (out_valid),
    .conv2d_input_V_data_0_V_TREADY (out_ready)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cycle   = 0;
  logic [15:0] q[$];
  int          pix = 0;
  int          my = 0;
  int          mx = 0;
  bit          rand_in = 1'b0;
  int          out_pct = 100;
  int          beats = 0;
  int          first_beat = -1;
  int          last_beat = -1;
  int          last_beat_edge = 0;
  int          last_hs_edge = 0;
  int          done_cnt = 0;
  int          done_edge = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cycle = cycle + 1;

  // Random output backpressure, changed just after each edge
  always @(posedge clk) begin
    #1;
    out_ready = ($urandom_range(0, 99) < out_pct);
  end

  // Output monitor: scoreboard compare, stall stability, ap_done tracking
  always @(negedge clk) begin
    if (ap_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_beat", 32'(q.size()), 32'd1);
        end else begin
          check("beat", 32'(out_data), 32'(q.pop_front()));
        end
        if (beats == 0) first_beat = int'(out_data);
        last_beat      = int'(out_data);
        last_beat_edge = cycle;
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (ap_done) begin
        done_cnt++;
        done_edge = cycle;
      end
    end
  end

  task automatic start(input int y, input int x);
    @(posedge clk); #1;
    check("idle_before_start", 32'(ap_idle), 32'd1);
    crop_y   = 7'(y);
    crop_x   = 8'(x);
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    check("ready_pulse", 32'(ap_ready), 32'd1);
    check("idle_low_run", 32'(ap_idle), 32'd0);
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(ap_ready), 32'd0);
  endtask

  // Offer ramp pixels until 'upto' are accepted or 'budget' cycles pass
  task automatic drive(input int upto, input int budget);
    int n;
    int r;
    int c;
    bit win;
    bit hs;
    n = 0;
    while (pix < upto && n < budget) begin
      r   = pix / IC;
      c   = pix % IC;
      win = (r >= my) && (r < my + OR) && (c >= mx) && (c < mx + OC);
      in_data  = 16'(pix);
      in_valid = (rand_in && win) ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      if (hs) begin
        if (win) q.push_back(16'(pix));
        last_hs_edge = cycle;
        pix++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int y, input int x, input bit rnd,
                           input int exp_first, input int exp_last, input bit chk_lat);
    int d0;
    int n;
    my      = (y > IR - OR) ? IR - OR : y;
    mx      = (x > IC - OC) ? IC - OC : x;
    rand_in = rnd;
    out_pct = rnd ? 50 : 100;
    pix     = 0;
    beats   = 0;
    d0      = done_cnt;
    start(y, x);
    drive(TOTAL, 60000);
    check("frame_all_accepted", 32'(pix), 32'(TOTAL));
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    if (chk_lat) check("done_latency", 32'(done_edge - last_hs_edge), 32'd2);
    check("done_after_last_beat", 32'(done_edge >= last_beat_edge + 3), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_single_pulse", 32'(done_cnt - d0), 32'd1);
    check("beat_count", 32'(beats), 32'(OR * OC));
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    check("first_beat", 32'(first_beat), 32'(exp_first));
    check("last_beat", 32'(last_beat), 32'(exp_last));
    check("idle_after_done", 32'(ap_idle), 32'd1);
    $display("[TB] frame crop(%0d,%0d) rnd=%0d: %0d beats, first 0x%04h last 0x%04h",
             y, x, rnd, beats, first_beat, last_beat);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_done"},   32'(ap_done),   32'd0);
    check({tag, "_ready"},  32'(ap_ready),  32'd0);
    check({tag, "_idle"},   32'(ap_idle),   32'd1);
    check({tag, "_tready"}, 32'(in_ready),  32'd0);
    check({tag, "_tvalid"}, 32'(out_valid), 32'd0);
    check({tag, "_tdata"},  32'(out_data),  32'd0);
  endtask

  initial begin
    ap_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ap_rst = 1'b0;
    check_reset_values("reset");

    // Stall output with window at (0,0): only 2 pixels fit, then input blocks
    my = 0; mx = 0; rand_in = 1'b0; out_pct = 0; pix = 0; beats = 0;
    start(0, 0);
    drive(500, 100);
    check("stall_accepted", 32'(pix), 32'd2);
    @(negedge clk);
    check("stall_tready_low", 32'(in_ready), 32'd0);
    check("stall_no_output", 32'(beats), 32'd0);
    out_pct = 100;
    drive(500, 2000);
    check("release_reach_500", 32'(pix), 32'd500);
    check("release_first_beat", 32'(first_beat), 32'h0000);
    $display("[TB] stall/release crop(0,0): %0d input beats, %0d output beats", pix, beats);

    // One-cycle reset mid-frame, then a clean frame
    out_pct = 0;
    @(posedge clk); #1;
    ap_rst = 1'b1;
    @(posedge clk); #1;
    ap_rst = 1'b0;
    check_reset_values("midreset");
    q.delete();
    $display("[TB] mid-frame reset applied after %0d input beats", pix);

    run_frame(10, 10, 1'b0, 16'h064A, 16'h23D9, 1'b1);
    run_frame(10, 10, 1'b1, 16'h064A, 16'h23D9, 1'b0);
    run_frame(52, 112, 1'b0, 16'h20F0, 16'h3E7F, 1'b0);
    run_frame(90, 150, 1'b1, 16'h20F0, 16'h3E7F, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
